wb_ctrl: RTL and testbench
==========================

WB_CTRL -- requirements
Module: wb_ctrl

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-low reset.
REQ-003 in_valid  input  1  writeback record offered by MEM stage.
REQ-004 in_ready  output  1  record accepted on edge where in_valid&in_ready.
REQ-005 in_addr  input  4  destination register; in_data  input  16  primary result; in_we  input  1  primary write request.
REQ-006 in_hi  input  16  secondary result for R15; in_r15_we  input  1  R15 write request.
REQ-007 W_addr  output  4, W_data  output  16, reg_WE  output  1  register-file general write port.
REQ-008 W_R15  output  16, R15_WE  output  1  register-file dedicated R15 write port.
REQ-009 OP1_addr, OP2_addr  input  4  decode-stage read addresses.
REQ-010 fwd1_hit, fwd2_hit  output  1; fwd1_data, fwd2_data  output  16  bypass of pending writes.
REQ-011 pend_cnt  output  2  number of queued records (0..2).

Function
REQ-012 Block SHALL hold a 2-entry FIFO of records {addr, data, we, hi, r15_we}; in_ready = (pend_cnt < 2), independent of same-cycle dequeue.
REQ-013 Write-port outputs SHALL decode combinationally from FIFO head and FSM state; all zero when FIFO empty.
REQ-014 Record accepted at edge N SHALL drive write ports during cycle N+1 (when it is head) and commit at edge N+1; throughput one record per cycle absent conflicts.
REQ-015 FSM states: IDLE, SPLIT; reset to IDLE.
REQ-016 IDLE, non-conflict head: reg_WE = we & (addr != 0), W_addr = addr, W_data = data; R15_WE = r15_we, W_R15 = hi; head dequeued at edge.
REQ-017 Write with addr 0 SHALL be suppressed (no R0 exists); r15 part of same record still issued.
REQ-018 Conflict = head.we & head.addr==4'hF & head.r15_we: in IDLE drive only R15_WE=1, W_R15=hi, reg_WE=0, go SPLIT, head retained.
REQ-019 SPLIT: drive reg_WE=1, W_addr=4'hF, W_data=data, R15_WE=0; dequeue head, return to IDLE; final R15 = data (primary wins).
REQ-020 Record with we=0 and r15_we=0 SHALL dequeue in one cycle with no write strobes.
REQ-021 Simultaneous enqueue and dequeue with pend_cnt=1 SHALL keep pend_cnt=1, ordering preserved.
REQ-022 fwdN_hit=1 when any queued record will write register OP N address: (we & addr==OPaddr & addr!=0) or (r15_we & OPaddr==4'hF); OPaddr==0 never hits.
REQ-023 Multiple hits: newest record supplies fwdN_data; within one record targeting R15 via both paths, data (not hi) supplied; in SPLIT, head still counts as pending for both paths.
REQ-024 No hit: fwdN_data = 16'h0000.

Reset
REQ-025 On rst low, immediately: FIFO emptied, pend_cnt=0, state IDLE, in_ready=1, all write strobes and fwd outputs 0.
REQ-026 Reset mid-operation (including in SPLIT) SHALL discard queued records; no write strobe after rst asserts.
REQ-027 First acceptance possible on first rising edge after rst deasserts.

Configuration
REQ-028 Macro WB_FWD_EN: defined -> forwarding per REQ-022..024; undefined -> fwd1_hit, fwd2_hit, fwd1_data, fwd2_data tied to 0, no comparator logic; ports remain present.

Verification
REQ-029 Accept {addr=3, data=16'h1234, we=1} -> next cycle reg_WE=1, W_addr=3, W_data=16'h1234, R15_WE=0, pend_cnt 1 then 0.
REQ-030 Accept {addr=F, data=16'hAAAA, we=1, hi=16'h5555, r15_we=1} -> cycle 1 R15_WE=1/W_R15=5555, cycle 2 reg_WE=1/W_data=AAAA, in between pend_cnt=1.
REQ-031 Accept {addr=0, we=1, hi=16'h0042, r15_we=1} -> reg_WE=0, R15_WE=1, W_R15=16'h0042.
REQ-032 Three back-to-back valid records while head is conflict -> in_ready=0 after two accepted; third accepted after first dequeues; order preserved.
REQ-033 Queue {addr=5,data=1} then {addr=5,data=2}, OP1_addr=5 -> fwd1_hit=1, fwd1_data=2 (WB_FWD_EN defined); 0 when undefined.
REQ-034 Assert rst during SPLIT -> reg_WE, R15_WE drop to 0 immediately, pend_cnt=0, no further writes after release.

Source files
------------

// File: rtl/wb_ctrl_if.sv
// Writeback controller bus: MEM-stage record input, register-file write ports,
// decode-stage operand lookup and forwarding results.
interface wb_ctrl_if;
  localparam int unsigned AW = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned CW = 2;

  // record offered by MEM stage
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic          in_we;
  logic [DW-1:0] in_hi;
  logic          in_r15_we;

  // register-file write ports
  logic [AW-1:0] W_addr;
  logic [DW-1:0] W_data;
  logic          reg_WE;
  logic [DW-1:0] W_R15;
  logic          R15_WE;

  // decode-stage bypass
  logic [AW-1:0] OP1_addr;
  logic [AW-1:0] OP2_addr;
  logic          fwd1_hit;
  logic          fwd2_hit;
  logic [DW-1:0] fwd1_data;
  logic [DW-1:0] fwd2_data;

  logic [CW-1:0] pend_cnt;

  modport master (
    output in_valid, in_addr, in_data, in_we, in_hi, in_r15_we, OP1_addr, OP2_addr,
    input  in_ready, W_addr, W_data, reg_WE, W_R15, R15_WE,
           fwd1_hit, fwd2_hit, fwd1_data, fwd2_data, pend_cnt
  );

  modport slave (
    input  in_valid, in_addr, in_data, in_we, in_hi, in_r15_we, OP1_addr, OP2_addr,
    output in_ready, W_addr, W_data, reg_WE, W_R15, R15_WE,
           fwd1_hit, fwd2_hit, fwd1_data, fwd2_data, pend_cnt
  );
endinterface

// File: rtl/wb_ctrl.sv
// Writeback controller: 2-entry record FIFO feeding the register file, with
// R15 dual-write splitting and pending-write bypass to decode.
// Optional feature macro: WB_FWD_EN (forwarding comparators; outputs tied to 0
// when undefined).
module wb_ctrl (
  input logic      clk,
  input logic      rst,
  wb_ctrl_if.slave bus
);
  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 16;
  localparam int unsigned CW    = 2;
  localparam int unsigned DEPTH = 2;
  localparam logic [AW-1:0] R15_ADDR = AW'(15);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          we;
    logic [DW-1:0] hi;
    logic          r15_we;
  } rec_t;

  typedef enum logic {IDLE, SPLIT} state_t;

  state_t        state_q, state_d;
  rec_t          fifo_q [DEPTH];
  logic          rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] cnt_q;

  rec_t          head, in_rec;
  logic          head_vld, conflict, in_ready_c, enq, deq;

  logic          reg_we_c, r15_we_c;
  logic [AW-1:0] w_addr_c;
  logic [DW-1:0] w_data_c, w_r15_c;

  assign in_rec     = '{addr: bus.in_addr, data: bus.in_data, we: bus.in_we,
                        hi: bus.in_hi, r15_we: bus.in_r15_we};
  assign head       = fifo_q[rd_ptr_q];
  assign head_vld   = (cnt_q != '0);
  assign conflict   = head.we & (head.addr == R15_ADDR) & head.r15_we;
  // Full-only backpressure: a same-cycle dequeue does not free a slot early.
  assign in_ready_c = (cnt_q < CW'(DEPTH));
  assign enq        = bus.in_valid & in_ready_c;

  // Record storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (enq) begin
        fifo_q[wr_ptr_q] <= in_rec;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (deq) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + CW'(enq) - CW'(deq);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Head decode: R15 dual-write records issue hi first, then the primary data.
  always_comb begin
    state_d  = state_q;
    deq      = 1'b0;
    reg_we_c = 1'b0;
    w_addr_c = '0;
    w_data_c = '0;
    r15_we_c = 1'b0;
    w_r15_c  = '0;
    case (state_q)
      IDLE: begin
        if (head_vld) begin
          if (conflict) begin
            r15_we_c = 1'b1;
            w_r15_c  = head.hi;
            state_d  = SPLIT;
          end else begin
            reg_we_c = head.we & (head.addr != '0);
            w_addr_c = head.addr;
            w_data_c = head.data;
            r15_we_c = head.r15_we;
            w_r15_c  = head.hi;
            deq      = 1'b1;
          end
        end
      end
      SPLIT: begin
        reg_we_c = 1'b1;
        w_addr_c = R15_ADDR;
        w_data_c = head.data;
        deq      = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready = in_ready_c;
  assign bus.pend_cnt = cnt_q;
  assign bus.reg_WE   = reg_we_c;
  assign bus.W_addr   = w_addr_c;
  assign bus.W_data   = w_data_c;
  assign bus.R15_WE   = r15_we_c;
  assign bus.W_R15    = w_r15_c;

`ifdef WB_FWD_EN
  logic [DW:0] fwd1_c, fwd2_c;

  // {hit, data} for one record against one read address; primary path wins.
  function automatic logic [DW:0] rec_hit(input rec_t r, input logic [AW-1:0] op);
    logic [DW:0] res;
    res = '0;
    if (op != '0) begin
      if (r.we && (r.addr == op))                res = {1'b1, r.data};
      else if (r.r15_we && (op == R15_ADDR))     res = {1'b1, r.hi};
    end
    return res;
  endfunction

  // Oldest-to-newest scan so the newest matching record supplies the data.
  function automatic logic [DW:0] fwd_lookup(input rec_t q0, input rec_t q1,
                                             input logic [CW-1:0] n,
                                             input logic [AW-1:0] op);
    logic [DW:0] res, h;
    res = '0;
    h   = rec_hit(q0, op);
    if ((n != '0) && h[DW]) res = h;
    h   = rec_hit(q1, op);
    if ((n == CW'(DEPTH)) && h[DW]) res = h;
    return res;
  endfunction

  // Bypass of every still-queued write, including a head that is mid-split.
  always_comb begin
    fwd1_c = fwd_lookup(fifo_q[rd_ptr_q], fifo_q[~rd_ptr_q], cnt_q, bus.OP1_addr);
    fwd2_c = fwd_lookup(fifo_q[rd_ptr_q], fifo_q[~rd_ptr_q], cnt_q, bus.OP2_addr);
  end

  assign bus.fwd1_hit  = fwd1_c[DW];
  assign bus.fwd1_data = fwd1_c[DW-1:0];
  assign bus.fwd2_hit  = fwd2_c[DW];
  assign bus.fwd2_data = fwd2_c[DW-1:0];
`else
  logic unused_op_addr;
  assign unused_op_addr = ^{bus.OP1_addr, bus.OP2_addr};

  assign bus.fwd1_hit  = 1'b0;
  assign bus.fwd1_data = '0;
  assign bus.fwd2_hit  = 1'b0;
  assign bus.fwd2_data = '0;
`endif

endmodule

// File: tb/tb_wb_ctrl.sv
// Testbench for wb_ctrl: directed scenarios plus randomized traffic checked
// against a queue-based reference model.
module tb_wb_ctrl;
`ifdef WB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  wb_ctrl_if bus();
  wb_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0]  addr;
    logic [15:0] data;
    logic        we;
    logic [15:0] hi;
    logic        r15_we;
  } rec_t;

  typedef struct {
    logic        reg_we;
    logic [3:0]  w_addr;
    logic [15:0] w_data;
    logic        r15_we;
    logic [15:0] w_r15;
  } exp_t;

  rec_t mq[$];
  bit   m_half;

  // Expected write ports from the model queue head.
  function automatic exp_t m_expect();
    exp_t e;
    rec_t h;
    bit   cf;
    e = '{reg_we: 1'b0, w_addr: 4'h0, w_data: 16'h0, r15_we: 1'b0, w_r15: 16'h0};
    if (mq.size() != 0) begin
      h  = mq[0];
      cf = h.we && (h.addr == 4'hF) && h.r15_we;
      if (cf && !m_half) begin
        e.r15_we = 1'b1; e.w_r15 = h.hi;
      end else if (cf) begin
        e.reg_we = 1'b1; e.w_addr = 4'hF; e.w_data = h.data;
      end else begin
        e.reg_we = h.we && (h.addr != 4'h0); e.w_addr = h.addr; e.w_data = h.data;
        e.r15_we = h.r15_we; e.w_r15 = h.hi;
      end
    end
    return e;
  endfunction

  // Expected forwarding for one read address (newest record wins).
  function automatic void m_fwd(input logic [3:0] op, output logic hit, output logic [15:0] data);
    hit = 1'b0; data = 16'h0;
    if (FWD && op != 4'h0) begin
      foreach (mq[i]) begin
        if (mq[i].we && mq[i].addr == op) begin hit = 1'b1; data = mq[i].data; end
        else if (mq[i].r15_we && op == 4'hF) begin hit = 1'b1; data = mq[i].hi; end
      end
    end
  endfunction

  // Advance the model by one clock edge.
  function automatic void m_step(input bit acc, input rec_t r);
    rec_t h;
    bit   cf;
    if (mq.size() != 0) begin
      h  = mq[0];
      cf = h.we && (h.addr == 4'hF) && h.r15_we;
      if (cf && !m_half) m_half = 1'b1;
      else begin
        void'(mq.pop_front());
        m_half = 1'b0;
      end
    end
    if (acc) mq.push_back(r);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] a, input logic [15:0] d,
                       input logic we, input logic [15:0] hi, input logic r15);
    bus.in_valid = v; bus.in_addr = a; bus.in_data = d;
    bus.in_we = we; bus.in_hi = hi; bus.in_r15_we = r15;
  endtask

  task automatic test_reset();
    bus.OP1_addr = 4'h7; bus.OP2_addr = 4'hF;
    drive(1'b1, 4'h7, 16'h0BEE, 1'b1, 16'h0000, 1'b0);
    #12;
    total++; if (bus.pend_cnt !== 2'd0) begin bad++; $display("FAIL reset.pend_cnt got=%0d want=0", bus.pend_cnt); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset.in_ready got=%0b want=1", bus.in_ready); end
    total++; if ({bus.reg_WE, bus.R15_WE} !== 2'b00) begin bad++; $display("FAIL reset.strobes got=%b want=00", {bus.reg_WE, bus.R15_WE}); end
    total++; if ({bus.fwd1_hit, bus.fwd1_data} !== 17'h0) begin bad++; $display("FAIL reset.fwd1 got=%h want=0", {bus.fwd1_hit, bus.fwd1_data}); end
    @(negedge clk); rst = 1'b1;
    tick();
    drive(1'b0, 4'h0, 16'h0, 1'b0, 16'h0, 1'b0);
    total++; if (bus.pend_cnt !== 2'd1) begin bad++; $display("FAIL first_acc.pend_cnt got=%0d want=1", bus.pend_cnt); end
    total++; if (bus.reg_WE !== 1'b1 || bus.W_addr !== 4'h7 || bus.W_data !== 16'h0BEE) begin
      bad++; $display("FAIL first_acc.write got we=%b a=%h d=%h want we=1 a=7 d=0bee", bus.reg_WE, bus.W_addr, bus.W_data); end
    total++; if (bus.fwd1_hit !== FWD || bus.fwd1_data !== (FWD ? 16'h0BEE : 16'h0)) begin
      bad++; $display("FAIL first_acc.fwd1 got hit=%b d=%h", bus.fwd1_hit, bus.fwd1_data); end
    tick();
    total++; if (bus.pend_cnt !== 2'd0) begin bad++; $display("FAIL first_acc.drain got=%0d want=0", bus.pend_cnt); end
  endtask

  task automatic test_single();
    drive(1'b1, 4'h3, 16'h1234, 1'b1, 16'h0000, 1'b0);
    tick();
    drive(1'b0, 4'h0, 16'h0, 1'b0, 16'h0, 1'b0);
    total++; if (bus.reg_WE !== 1'b1 || bus.W_addr !== 4'h3 || bus.W_data !== 16'h1234 || bus.R15_WE !== 1'b0) begin
      bad++; $display("FAIL single.write got we=%b a=%h d=%h r15we=%b", bus.reg_WE, bus.W_addr, bus.W_data, bus.R15_WE); end
    total++; if (bus.pend_cnt !== 2'd1) begin bad++; $display("FAIL single.pend got=%0d want=1", bus.pend_cnt); end
    tick();
    total++; if (bus.pend_cnt !== 2'd0 || bus.reg_WE !== 1'b0 || bus.W_data !== 16'h0) begin
      bad++; $display("FAIL single.empty got pend=%0d we=%b d=%h", bus.pend_cnt, bus.reg_WE, bus.W_data); end
  endtask

  task automatic test_split();
    drive(1'b1, 4'hF, 16'hAAAA, 1'b1, 16'h5555, 1'b1);
    tick();
    drive(1'b0, 4'h0, 16'h0, 1'b0, 16'h0, 1'b0);
    total++; if (bus.R15_WE !== 1'b1 || bus.W_R15 !== 16'h5555 || bus.reg_WE !== 1'b0) begin
      bad++; $display("FAIL split.c1 got r15we=%b w15=%h we=%b", bus.R15_WE, bus.W_R15, bus.reg_WE); end
    total++; if (bus.pend_cnt !== 2'd1) begin bad++; $display("FAIL split.pend1 got=%0d want=1", bus.pend_cnt); end
    tick();
    total++; if (bus.reg_WE !== 1'b1 || bus.W_addr !== 4'hF || bus.W_data !== 16'hAAAA || bus.R15_WE !== 1'b0) begin
      bad++; $display("FAIL split.c2 got we=%b a=%h d=%h r15we=%b", bus.reg_WE, bus.W_addr, bus.W_data, bus.R15_WE); end
    total++; if (bus.pend_cnt !== 2'd1) begin bad++; $display("FAIL split.pend2 got=%0d want=1", bus.pend_cnt); end
    tick();
    total++; if (bus.pend_cnt !== 2'd0 || bus.reg_WE !== 1'b0 || bus.R15_WE !== 1'b0) begin
      bad++; $display("FAIL split.done got pend=%0d we=%b r15we=%b", bus.pend_cnt, bus.reg_WE, bus.R15_WE); end
  endtask

  task automatic test_r0();
    bus.OP1_addr = 4'h0; bus.OP2_addr = 4'h3;
    drive(1'b1, 4'h0, 16'h7777, 1'b1, 16'h0042, 1'b1);
    tick();
    drive(1'b0, 4'h0, 16'h0, 1'b0, 16'h0, 1'b0);
    total++; if (bus.reg_WE !== 1'b0 || bus.R15_WE !== 1'b1 || bus.W_R15 !== 16'h0042) begin
      bad++; $display("FAIL r0.write got we=%b r15we=%b w15=%h", bus.reg_WE, bus.R15_WE, bus.W_R15); end
    total++; if (bus.fwd1_hit !== 1'b0 || bus.fwd2_hit !== 1'b0 || bus.fwd2_data !== 16'h0) begin
      bad++; $display("FAIL r0.nohit got h1=%b h2=%b d2=%h", bus.fwd1_hit, bus.fwd2_hit, bus.fwd2_data); end
    tick();
    total++; if (bus.pend_cnt !== 2'd0) begin bad++; $display("FAIL r0.drain got=%0d want=0", bus.pend_cnt); end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 4'hF, 16'h1111, 1'b1, 16'h2222, 1'b1);
    tick();
    drive(1'b1, 4'h4, 16'h4444, 1'b1, 16'h0, 1'b0);
    total++; if (bus.R15_WE !== 1'b1 || bus.W_R15 !== 16'h2222 || bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL b2b.c1 got r15we=%b w15=%h rdy=%b", bus.R15_WE, bus.W_R15, bus.in_ready); end
    tick();
    drive(1'b1, 4'h6, 16'h6666, 1'b1, 16'h0, 1'b0);
    total++; if (bus.in_ready !== 1'b0 || bus.pend_cnt !== 2'd2) begin
      bad++; $display("FAIL b2b.full got rdy=%b pend=%0d want rdy=0 pend=2", bus.in_ready, bus.pend_cnt); end
    total++; if (bus.reg_WE !== 1'b1 || bus.W_addr !== 4'hF || bus.W_data !== 16'h1111) begin
      bad++; $display("FAIL b2b.c2 got we=%b a=%h d=%h", bus.reg_WE, bus.W_addr, bus.W_data); end
    tick();
    total++; if (bus.in_ready !== 1'b1 || bus.pend_cnt !== 2'd1 || bus.W_addr !== 4'h4 || bus.W_data !== 16'h4444) begin
      bad++; $display("FAIL b2b.c3 got rdy=%b pend=%0d a=%h d=%h", bus.in_ready, bus.pend_cnt, bus.W_addr, bus.W_data); end
    tick();
    drive(1'b0, 4'h0, 16'h0, 1'b0, 16'h0, 1'b0);
    total++; if (bus.pend_cnt !== 2'd1 || bus.reg_WE !== 1'b1 || bus.W_addr !== 4'h6 || bus.W_data !== 16'h6666) begin
      bad++; $display("FAIL b2b.c4 got pend=%0d we=%b a=%h d=%h", bus.pend_cnt, bus.reg_WE, bus.W_addr, bus.W_data); end
    tick();
    total++; if (bus.pend_cnt !== 2'd0) begin bad++; $display("FAIL b2b.drain got=%0d want=0", bus.pend_cnt); end
  endtask

  task automatic test_forward();
    bus.OP1_addr = 4'h5; bus.OP2_addr = 4'hF;
    drive(1'b1, 4'hF, 16'h00A1, 1'b1, 16'h00B1, 1'b1);
    tick();
    drive(1'b1, 4'h5, 16'h0001, 1'b1, 16'h0, 1'b0);
    total++; if (bus.fwd2_hit !== FWD || bus.fwd2_data !== (FWD ? 16'h00A1 : 16'h0) || bus.fwd1_hit !== 1'b0) begin
      bad++; $display("FAIL fwd.c1 got h2=%b d2=%h h1=%b", bus.fwd2_hit, bus.fwd2_data, bus.fwd1_hit); end
    tick();
    drive(1'b1, 4'h5, 16'h0002, 1'b1, 16'h0, 1'b0);
    total++; if (bus.fwd1_hit !== FWD || bus.fwd1_data !== (FWD ? 16'h0001 : 16'h0)) begin
      bad++; $display("FAIL fwd.c2a got h1=%b d1=%h", bus.fwd1_hit, bus.fwd1_data); end
    total++; if (bus.fwd2_hit !== FWD || bus.fwd2_data !== (FWD ? 16'h00A1 : 16'h0)) begin
      bad++; $display("FAIL fwd.split got h2=%b d2=%h", bus.fwd2_hit, bus.fwd2_data); end
    tick();
    total++; if (bus.fwd2_hit !== 1'b0 || bus.fwd1_data !== (FWD ? 16'h0001 : 16'h0)) begin
      bad++; $display("FAIL fwd.c3 got h2=%b d1=%h", bus.fwd2_hit, bus.fwd1_data); end
    tick();
    drive(1'b0, 4'h0, 16'h0, 1'b0, 16'h0, 1'b0);
    total++; if (bus.fwd1_hit !== FWD || bus.fwd1_data !== (FWD ? 16'h0002 : 16'h0)) begin
      bad++; $display("FAIL fwd.newer got h1=%b d1=%h", bus.fwd1_hit, bus.fwd1_data); end
    tick();
    total++; if (bus.fwd1_hit !== 1'b0 || bus.fwd1_data !== 16'h0) begin
      bad++; $display("FAIL fwd.empty got h1=%b d1=%h", bus.fwd1_hit, bus.fwd1_data); end
    // two records targeting R15: newest (via hi) supplies the data
    drive(1'b1, 4'hF, 16'h0111, 1'b1, 16'h0222, 1'b1);
    tick();
    drive(1'b1, 4'h9, 16'h0333, 1'b0, 16'h0444, 1'b1);
    tick();
    drive(1'b0, 4'h0, 16'h0, 1'b0, 16'h0, 1'b0);
    total++; if (bus.fwd2_hit !== FWD || bus.fwd2_data !== (FWD ? 16'h0444 : 16'h0)) begin
      bad++; $display("FAIL fwd.r15newest got h2=%b d2=%h", bus.fwd2_hit, bus.fwd2_data); end
    tick(); tick();
    total++; if (bus.pend_cnt !== 2'd0) begin bad++; $display("FAIL fwd.drain got=%0d want=0", bus.pend_cnt); end
  endtask

  task automatic test_reset_split();
    bus.OP1_addr = 4'h2; bus.OP2_addr = 4'hF;
    drive(1'b1, 4'hF, 16'h0C0C, 1'b1, 16'h0D0D, 1'b1);
    tick();
    drive(1'b1, 4'h2, 16'h2222, 1'b1, 16'h0, 1'b0);
    tick();
    drive(1'b0, 4'h0, 16'h0, 1'b0, 16'h0, 1'b0);
    total++; if (bus.reg_WE !== 1'b1 || bus.pend_cnt !== 2'd2) begin
      bad++; $display("FAIL rst_split.pre got we=%b pend=%0d", bus.reg_WE, bus.pend_cnt); end
    #2 rst = 1'b0;
    #1;
    total++; if (bus.reg_WE !== 1'b0 || bus.R15_WE !== 1'b0 || bus.pend_cnt !== 2'd0 || bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL rst_split.now got we=%b r15we=%b pend=%0d rdy=%b", bus.reg_WE, bus.R15_WE, bus.pend_cnt, bus.in_ready); end
    total++; if (bus.fwd1_hit !== 1'b0 || bus.fwd2_hit !== 1'b0) begin
      bad++; $display("FAIL rst_split.fwd got h1=%b h2=%b", bus.fwd1_hit, bus.fwd2_hit); end
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (bus.reg_WE !== 1'b0 || bus.R15_WE !== 1'b0 || bus.pend_cnt !== 2'd0) begin
        bad++; $display("FAIL rst_split.after%0d got we=%b r15we=%b pend=%0d", i, bus.reg_WE, bus.R15_WE, bus.pend_cnt); end
    end
  endtask

  function automatic logic [3:0] pick_addr();
    case ($urandom_range(0, 3))
      0:       return 4'h0;
      1:       return 4'hF;
      2:       return 4'h5;
      default: return 4'($urandom);
    endcase
  endfunction

  task automatic test_random();
    exp_t        e;
    rec_t        r;
    bit          acc;
    logic        h1, h2;
    logic [15:0] d1, d2;
    mq.delete();
    m_half = 1'b0;
    for (int c = 0; c < 600; c++) begin
      r = '{addr: pick_addr(), data: 16'($urandom), we: 1'($urandom),
            hi: 16'($urandom), r15_we: 1'($urandom)};
      drive(1'($urandom_range(0, 3) != 0), r.addr, r.data, r.we, r.hi, r.r15_we);
      bus.OP1_addr = pick_addr();
      bus.OP2_addr = pick_addr();
      #1;
      e = m_expect();
      m_fwd(bus.OP1_addr, h1, d1);
      m_fwd(bus.OP2_addr, h2, d2);
      total++; if (bus.pend_cnt !== 2'(mq.size()) || bus.in_ready !== (mq.size() < 2)) begin
        bad++; $display("FAIL rand.occ c=%0d got pend=%0d rdy=%b want pend=%0d", c, bus.pend_cnt, bus.in_ready, mq.size()); end
      total++; if (bus.reg_WE !== e.reg_we || (e.reg_we && (bus.W_addr !== e.w_addr || bus.W_data !== e.w_data))) begin
        bad++; $display("FAIL rand.reg c=%0d got we=%b a=%h d=%h want we=%b a=%h d=%h", c,
                        bus.reg_WE, bus.W_addr, bus.W_data, e.reg_we, e.w_addr, e.w_data); end
      total++; if (bus.R15_WE !== e.r15_we || (e.r15_we && bus.W_R15 !== e.w_r15)) begin
        bad++; $display("FAIL rand.r15 c=%0d got we=%b d=%h want we=%b d=%h", c, bus.R15_WE, bus.W_R15, e.r15_we, e.w_r15); end
      total++; if (bus.fwd1_hit !== h1 || bus.fwd1_data !== d1 || bus.fwd2_hit !== h2 || bus.fwd2_data !== d2) begin
        bad++; $display("FAIL rand.fwd c=%0d got %b/%h %b/%h want %b/%h %b/%h", c,
                        bus.fwd1_hit, bus.fwd1_data, bus.fwd2_hit, bus.fwd2_data, h1, d1, h2, d2); end
      acc = bus.in_valid && (mq.size() < 2);
      @(posedge clk);
      m_step(acc, r);
      #1;
    end
    drive(1'b0, 4'h0, 16'h0, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 8 && bus.pend_cnt !== 2'd0; i++) tick();
    total++; if (bus.pend_cnt !== 2'd0) begin bad++; $display("FAIL rand.drain got=%0d want=0", bus.pend_cnt); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    drive(1'b0, 4'h0, 16'h0, 1'b0, 16'h0, 1'b0);
    bus.OP1_addr = 4'h0;
    bus.OP2_addr = 4'h0;
    test_reset();
    test_single();
    test_split();
    test_r0();
    test_back_to_back();
    test_forward();
    test_reset_split();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
